// File: rtl/uart_pkg.sv
// Shared UART types: FSM state encoding and default payload width.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int DEFAULT_DATA_BITS = 8;

endpackage

// File: rtl/baud_gen.sv
// Bit-period timer: tick is high on the last cycle of each CLKS_PER_BIT period.
// clr holds the count at zero so a new frame starts on a clean period boundary.
module baud_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // Wraps straight back to zero on the last cycle, so no terminal-count overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS LSB-first, one stop bit, CLKS_PER_BIT cycles each.
// Accepts a byte only in IDLE (tx_ready); frame-to-frame period is (DATA_BITS+2)*CLKS_PER_BIT+1.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  state_t               state;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 tick;
  logic                 baud_clr;

  assign baud_clr = (state == IDLE);
  assign busy     = (state != IDLE);

  baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (baud_clr),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      txd      <= 1'b1;
      tx_ready <= 1'b0;
      tx_done  <= 1'b0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            state    <= START;
            txd      <= 1'b0;
            tx_ready <= 1'b0;
            shreg    <= tx_data;
            bit_idx  <= '0;
          end else begin
            tx_ready <= 1'b1;
            txd      <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            txd   <= shreg[0];
            shreg <= shreg >> 1;
          end
        end
        DATA: begin
          // The shift register always presents the next bit at position 0.
          if (tick) begin
            if (bit_idx == LAST_IDX) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              txd     <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            state    <= IDLE;
            tx_ready <= 1'b1;
            tx_done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
